// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x DEPTH register array for the elastic buffer.
// One synchronous write port, one asynchronous (combinational) read port.
module fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   // Storage is deliberately left unreset; the pointers decide what is valid.
   logic [WIDTH-1:0] mem_r [DEPTH];

   // Write the addressed entry on the rising edge when enabled.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Read is combinational so the oldest word falls through to the output.
   always_comb begin
      rd_data = mem_r[rd_addr];
   end

endmodule

// File: rtl/fifo_buffer.sv
// fifo_buffer: storing end of a valid/ready link. Holds up to DEPTH words in
// order, first-word fall-through, no same-cycle bypass when empty.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module fifo_buffer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
   localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             empty_s;
   logic             full_s;
   logic             push_s;
   logic             pop_s;
   logic [WIDTH-1:0] rd_data_s;

   // Flags and handshakes depend only on registered pointers, so no
   // combinational path exists from in_* to out_* or out_ready to in_ready.
   always_comb begin
      empty_s = (wr_ptr_r == rd_ptr_r);
      full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                (wr_ptr_r[AW] != rd_ptr_r[AW]);
      push_s  = in_valid && !full_s && !rst;
      pop_s   = !empty_s && out_ready && !rst;
   end

   // Advance pointers on accepted transfers; reset discards all stored words.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push_s),
      .wr_addr (wr_ptr_r[AW-1:0]),
      .wr_data (in_data),
      .rd_addr (rd_ptr_r[AW-1:0]),
      .rd_data (rd_data_s)
   );

   // Drive the link outputs; out_data is forced to zero while empty so stale
   // memory contents never leak out.
   always_comb begin
      in_ready  = !full_s;
      out_valid = !empty_s;
      count     = wr_ptr_r - rd_ptr_r;
      if (empty_s) begin
         out_data = {WIDTH{1'b0}};
      end else begin
         out_data = rd_data_s;
      end
   end

endmodule
